// File: rtl/adder_ctrl_pkg.sv
// Shared types and default parameters for the adder run controller.
package adder_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADB,
    SETTLE,
    ACCUM,
    WAIT_REL
  } ctrl_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int SETTLE_CYCLES_DEF   = 2;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/adder_run_controller_btn_sync_debounce.sv
// Two-flop synchronizer plus counting debouncer for one active-low push button.
// Emits a single registered pulse when the stable level goes 1 -> 0.
module btn_sync_debounce
  import adder_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Reset_L,
  input  logic raw_l,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= raw_l;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        // Level was 1 before the flip only for a press; releases stay silent.
        level <= ~level;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/adder_run_controller.sv
// Button-driven sequencer for the 16-bit adder/register datapath: one load_b or
// load_g enable pulse per debounced press, plus accumulate count and sticky carry.
module adder_run_controller
  import adder_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic             LoadB_L,
  input  logic             Run_L,
  input  logic             cout,
  output logic             load_b,
  output logic             load_g,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  ctrl_state_t         state, state_next;
  logic [SETTLE_W-1:0] settle_cnt, settle_next;
  logic                level_loadb, press_loadb;
  logic                level_run, press_run;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_loadb (
    .Clk     (Clk),
    .Reset_L (Reset_L),
    .raw_l   (LoadB_L),
    .level   (level_loadb),
    .press   (press_loadb)
  );

  btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .Clk     (Clk),
    .Reset_L (Reset_L),
    .raw_l   (Run_L),
    .level   (level_run),
    .press   (press_run)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
    end
  end

  // Presses outside IDLE are simply ignored, so held or repeated buttons never queue.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    unique case (state)
      IDLE: begin
        if (press_loadb) begin
          state_next = LOADB;
        end else if (press_run) begin
          state_next  = SETTLE;
          settle_next = SETTLE_W'(SETTLE_CYCLES - 1);
        end
      end
      LOADB:    state_next = WAIT_REL;
      SETTLE: begin
        if (settle_cnt == '0) state_next = ACCUM;
        else                  settle_next = settle_cnt - SETTLE_W'(1);
      end
      ACCUM:    state_next = WAIT_REL;
      WAIT_REL: if (level_loadb && level_run) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      overflow <= 1'b0;
      op_count <= '0;
    end else if (state == LOADB) begin
      overflow <= 1'b0;
      op_count <= '0;
    end else if (state == ACCUM) begin
      overflow <= overflow | cout;
      op_count <= sat_inc(op_count);
    end
  end

  assign load_b = (state == LOADB);
  assign load_g = (state == ACCUM);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_adder_run_controller.sv
// Directed bench for adder_run_controller with DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2.
module tb_adder_run_controller;

  localparam int DB = 4;
  localparam int ST = 2;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Reset_L;
  logic          LoadB_L;
  logic          Run_L;
  logic          cout;
  logic          load_b;
  logic          load_g;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] op_count;

  adder_run_controller #(
    .DEBOUNCE_CYCLES (DB),
    .SETTLE_CYCLES   (ST),
    .CNT_W           (CW)
  ) dut (
    .Clk      (Clk),
    .Reset_L  (Reset_L),
    .LoadB_L  (LoadB_L),
    .Run_L    (Run_L),
    .cout     (cout),
    .load_b   (load_b),
    .load_g   (load_g),
    .busy     (busy),
    .overflow (overflow),
    .op_count (op_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit b;
    bit r;
    bit c;
    int hold;
    int exp_nb;
    int exp_ng;
    int exp_cnt;
    int exp_ovf;
    int exp_off_b;
    int exp_off_g;
    int exp_off_busy;
    int exp_off_idle;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   nb, ng;
  int   off_b, off_g, off_busy, off_idle;
  bit   busy_seen;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outputs change only at posedge, so sampling 1ns later sees each cycle once.
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (load_b) nb++;
    if (load_g) ng++;
    if (busy) busy_seen = 1'b1;
    if (load_b && load_g) begin
      fails++;
      $display("FAIL pulse_overlap: load_b=1 load_g=1 at cycle %0d, expected never both", cyc);
    end
  endtask

  task automatic do_press(input bit b, input bit r, input bit c, input int hold);
    int start, rel;
    nb = 0; ng = 0;
    off_b = -1; off_g = -1; off_busy = -1; off_idle = -1;
    cout    = c;
    LoadB_L = ~b;
    Run_L   = ~r;
    start   = cyc;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (load_b && off_b < 0)   off_b    = cyc - start;
      if (load_g && off_g < 0)   off_g    = cyc - start;
      if (busy   && off_busy < 0) off_busy = cyc - start;
    end
    LoadB_L = 1'b1;
    Run_L   = 1'b1;
    rel     = cyc;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (!busy && off_idle < 0) off_idle = cyc - rel;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt;
    int start;

    // b r c hold nb ng cnt ovf off_b off_g off_busy off_idle
    vecs[0] = '{1, 0, 0, 20, 1, 0, 0, 0,  8, -1, 8, 8};
    vecs[1] = '{0, 1, 0, 50, 0, 1, 1, 0, -1, 10, 8, 8};
    vecs[2] = '{0, 1, 1, 20, 0, 1, 2, 1, -1, 10, 8, 8};
    vecs[3] = '{0, 1, 0, 15, 0, 1, 3, 1, -1, 10, 8, 8};
    vecs[4] = '{1, 1, 0, 20, 1, 0, 0, 0,  8, -1, 8, 8};
    vecs[5] = '{0, 1, 0, 20, 0, 1, 1, 0, -1, 10, 8, 8};
    vecs[6] = '{1, 0, 1, 12, 1, 0, 0, 0,  8, -1, 8, 8};

    // Reset with both buttons held
    Reset_L = 1'b0; LoadB_L = 1'b0; Run_L = 1'b0; cout = 1'b0;
    nb = 0; ng = 0;
    repeat (3) tick();
    check("rst_load_b",   load_b,   0);
    check("rst_load_g",   load_g,   0);
    check("rst_busy",     busy,     0);
    check("rst_overflow", overflow, 0);
    check("rst_op_count", op_count, 0);
    Reset_L = 1'b1;
    nb = 0; ng = 0; busy_seen = 1'b0;
    repeat (3) tick();
    LoadB_L = 1'b1; Run_L = 1'b1;
    repeat (10) tick();
    check("post_rst_no_load_b", nb, 0);
    check("post_rst_no_load_g", ng, 0);
    check("post_rst_idle",      busy_seen, 0);

    for (int i = 0; i < 7; i++) begin
      do_press(vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].hold);
      check($sformatf("v%0d_nb", i),       nb,       vecs[i].exp_nb);
      check($sformatf("v%0d_ng", i),       ng,       vecs[i].exp_ng);
      check($sformatf("v%0d_op_count", i), op_count, vecs[i].exp_cnt);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].exp_ovf);
      check($sformatf("v%0d_off_b", i),    off_b,    vecs[i].exp_off_b);
      check($sformatf("v%0d_off_g", i),    off_g,    vecs[i].exp_off_g);
      check($sformatf("v%0d_off_busy", i), off_busy, vecs[i].exp_off_busy);
      check($sformatf("v%0d_off_idle", i), off_idle, vecs[i].exp_off_idle);
    end

    // Bounce that settles released: nothing should happen
    nb = 0; ng = 0; busy_seen = 1'b0; cout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Run_L = 1'b0; tick(); tick();
      Run_L = 1'b1; tick(); tick();
    end
    repeat (12) tick();
    check("bounce_rel_ng",   ng,        0);
    check("bounce_rel_busy", busy_seen, 0);
    check("bounce_rel_cnt",  op_count,  0);

    // Bounce that settles pressed: exactly one accumulate
    nb = 0; ng = 0;
    for (int i = 0; i < 3; i++) begin
      Run_L = 1'b0; tick(); tick();
      Run_L = 1'b1; tick(); tick();
    end
    Run_L = 1'b0;
    repeat (20) tick();
    Run_L = 1'b1;
    repeat (12) tick();
    check("bounce_press_ng",  ng,       1);
    check("bounce_press_nb",  nb,       0);
    check("bounce_press_cnt", op_count, 1);
    check("bounce_press_idle", busy,    0);

    // Saturate op_count
    exp_cnt = 1;
    while (exp_cnt < 255) begin
      do_press(1'b0, 1'b1, 1'b0, 12);
      exp_cnt++;
    end
    check("sat_reach_255", op_count, 255);
    check("sat_overflow",  overflow, 0);
    do_press(1'b0, 1'b1, 1'b0, 12);
    check("sat_hold_255", op_count, 255);
    check("sat_extra_ng", ng,       1);

    // Reset while in SETTLE
    nb = 0; ng = 0;
    cout  = 1'b1;
    Run_L = 1'b0;
    start = cyc;
    repeat (8) tick();
    check("mid_settle_busy",   busy,   1);
    check("mid_settle_load_g", load_g, 0);
    Reset_L = 1'b0;
    tick();
    check("mid_rst_busy",     busy,     0);
    check("mid_rst_load_g",   load_g,   0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_overflow", overflow, 0);
    Run_L = 1'b1;
    tick(); tick();
    Reset_L = 1'b1;
    repeat (20) tick();
    check("mid_rst_no_load_g", ng, 0);
    check("mid_rst_no_load_b", nb, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_run_controller.md
Name: adder_run_controller

Overview:
- Sequences the 16-bit adder/register datapath from the raw push buttons LoadB_L and Run. Adder selection is unchanged.
- Synchronizes and debounces both buttons, then issues exactly one single-cycle load_b or load_g pulse per press.
- Waits a programmable settle time so the adder output is stable before load_g.
- Tracks accumulate count and a sticky carry-out (overflow) flag.
- Sits between the board buttons and the register unit. The register unit is then clocked by Clk with these pulses as enables, not by button edges.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a level change. Use 16 for simulation, 500000 on board.
- SETTLE_CYCLES, default 2: cycles between an accepted Run press and the load_g pulse. Legal range ≥1.
- CNT_W, default 8: width of op_count.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset_L  in  1  reset; one clock, reset is synchronous and active-low
- LoadB_L  in  1  raw LoadB push button, active-low, asynchronous to Clk
- Run_L  in  1  raw Run push button, active-low, asynchronous to Clk
- cout  in  1  carry-out of the adder
- load_b  out  1  one-cycle pulse: register loads switches
- load_g  out  1  one-cycle pulse: register loads adder sum
- busy  out  1  high whenever state ≠ IDLE
- overflow  out  1  sticky: a carry-out occurred in an accumulate since the last load_b
- op_count  out  CNT_W  number of accumulates since the last load_b, saturating

Behaviour:
- Reset (Reset_L low at a rising edge):
  - State = IDLE.
  - load_b = load_g = busy = overflow = 0; op_count = 0.
  - Both debounced levels = 1 (released); sync flops = 1; debounce and settle counters = 0.
  - Reset takes priority over everything and aborts any state, including SETTLE and WAIT_REL. No pulse is issued in the reset cycle.
- Per button (sub-module):
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized value ≠ the stable level, and clears to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - press = registered one-cycle pulse on a stable 1→0 transition. Releases produce no event.
- Latency: the raw input first sampled low at edge N → press high in cycle N+2+DEBOUNCE_CYCLES.
- FSM, with states from the shared package:
  - IDLE:
    - press_loadb → LOADB. If both presses occur in the same cycle, LoadB wins and the Run press is discarded.
    - Otherwise press_run → SETTLE, settle counter loaded with SETTLE_CYCLES−1.
  - LOADB: load_b = 1 for this cycle; overflow ← 0; op_count ← 0; → WAIT_REL.
  - SETTLE: if the counter is 0 → ACCUM, else decrement. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - ACCUM:
    - load_g = 1 for this cycle.
    - overflow ← overflow | cout, with cout sampled this cycle.
    - op_count ← op_count+1, saturating at all-ones with no wrap.
    - → WAIT_REL.
  - WAIT_REL: stay until both stable levels = 1 (released) → IDLE. Press events arriving in any non-IDLE state are dropped, not queued.
- Invariants:
  - load_b and load_g are never high together.
  - Each is high for exactly 1 cycle per accepted press.
  - Holding a button produces exactly one pulse.
- Pulse timing: load_b is high in cycle N+3+DEBOUNCE_CYCLES; load_g is high in cycle N+3+DEBOUNCE_CYCLES+SETTLE_CYCLES.
- Outputs are registered (state-decoded from flops); there is no combinational input→output path.

Decomposition:
- Package adder_ctrl_pkg:
  - enum typedef ctrl_state_t {IDLE, LOADB, SETTLE, ACCUM, WAIT_REL}
  - localparam defaults for DEBOUNCE_CYCLES and SETTLE_CYCLES
- Sub-module btn_sync_debounce: parameter DEBOUNCE_CYCLES; ports Clk, Reset_L, raw_l, level, press. Instantiated twice.
- The FSM, settle counter, overflow and op_count stay in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2, CNT_W=8.
1. Reset: hold Reset_L low 3 cycles with both buttons held pressed → all outputs 0, state IDLE. After release of Reset_L with buttons still held, no pulse occurs until a release and a fresh press.
2. LoadB press first sampled at edge N, held 20 cycles → single load_b in cycle N+7, busy from N+7 until release is debounced, op_count=0, overflow=0.
3. Run press at edge N with cout=0 → single load_g in cycle N+9. op_count 0→1; hold Run 50 cycles → still one pulse. Then press Run again with cout=1 → op_count=2, overflow=1.
4. Bounce: Run_L toggles low/high every 2 cycles for 12 cycles, then settles high → no press, no load_g, busy stays 0. Toggle every 2 cycles, then hold low → exactly one load_g.
5. Simultaneous: both buttons pressed on the same edge → only load_b pulses, load_g never pulses. After releasing both, a Run press gives load_g normally.
6. Saturation and reset mid-operation:
   - Force op_count to 255 via 255 accumulates, then do one more Run → op_count stays 255.
   - Assert Reset_L low during SETTLE → no load_g, outputs cleared next cycle.
